// File: rtl/video_flip_pkg.sv
// Shared state encoding and DMAC register map for the HDMI frame-flip controller.
package video_flip_pkg;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT_VS,
    ST_POLL_RD,
    ST_POLL_WAIT,
    ST_WR_SRC,
    ST_WR_X,
    ST_WR_Y,
    ST_WR_STRIDE,
    ST_WR_SUB
  } state_e;

  localparam logic [11:0] REG_CONTROL    = 12'h400;
  localparam logic [11:0] REG_SUBMIT     = 12'h408;
  localparam logic [11:0] REG_SRC_ADDR   = 12'h414;
  localparam logic [11:0] REG_X_LEN      = 12'h418;
  localparam logic [11:0] REG_Y_LEN      = 12'h41C;
  localparam logic [11:0] REG_SRC_STRIDE = 12'h424;

  localparam logic [31:0] CONTROL_ENABLE = 32'h1;
  localparam logic [31:0] SUBMIT_GO      = 32'h1;

endpackage

// File: rtl/video_flip_avm_if.sv
// Single-access Avalon-MM master: latches one read or write on start and holds
// address/strobe/data until the slave drops waitrequest.
module video_flip_avm_if
  import video_flip_pkg::*;
#(
  parameter int unsigned ADDR_W = 24
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              is_read,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ack,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid
);

  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              rd_q;
  logic              wr_q;

  assign ack = (rd_q | wr_q) & ~avm_waitrequest;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else if (start) begin
      addr_q  <= addr;
      wdata_q <= wdata;
      rd_q    <= is_read;
      wr_q    <= ~is_read;
    end else if (ack) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end
  end

  assign avm_address    = addr_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = 4'hF;
  assign rdata          = avm_readdata;
  assign rvalid         = avm_readdatavalid;

endmodule

// File: rtl/video_frame_flip_ctrl.sv
// Frame-flip controller: on vsync, programs the HDMI DMAC with a new frame buffer.
// Define FRAME_FLIP_POLL_EN to poll TRANSFER_SUBMIT for queue space before writing.
module video_frame_flip_ctrl
  import video_flip_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 24,
  parameter logic [ADDR_W-1:0] DMAC_BASE = '0,
  parameter int unsigned       POLL_MAX  = 255
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              vsync,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [23:0]       req_xlen,
  input  logic [15:0]       req_ylen,
  input  logic [23:0]       req_stride,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid
);

  localparam logic [ADDR_W-1:0] A_CONTROL = DMAC_BASE + ADDR_W'(REG_CONTROL);
  localparam logic [ADDR_W-1:0] A_SUBMIT  = DMAC_BASE + ADDR_W'(REG_SUBMIT);
  localparam logic [ADDR_W-1:0] A_SRC     = DMAC_BASE + ADDR_W'(REG_SRC_ADDR);
  localparam logic [ADDR_W-1:0] A_XLEN    = DMAC_BASE + ADDR_W'(REG_X_LEN);
  localparam logic [ADDR_W-1:0] A_YLEN    = DMAC_BASE + ADDR_W'(REG_Y_LEN);
  localparam logic [ADDR_W-1:0] A_STRIDE  = DMAC_BASE + ADDR_W'(REG_SRC_STRIDE);

  state_e            state_q;
  logic              issued_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
  logic              vs_prev_q;
  logic [31:0]       addr_q;
  logic [23:0]       xlen_q;
  logic [15:0]       ylen_q;
  logic [23:0]       stride_q;

  logic              start;
  logic              is_read;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic              ack;
  logic [31:0]       rd_data;
  logic              rd_valid;
  logic              vs_edge;
  logic              unused_rd;

`ifdef FRAME_FLIP_POLL_EN
  // Counter only has to hold POLL_MAX-1; the last busy reply triggers err.
  localparam int unsigned CNT_W = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
  localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_MAX - 1);
  logic [CNT_W-1:0] poll_cnt_q;
  logic             err_q;
  assign err       = err_q;
  assign unused_rd = ^rd_data[31:1];
`else
  assign err       = 1'b0;
  assign unused_rd = ^{rd_data, rd_valid};
`endif

  assign vs_edge   = vsync & ~vs_prev_q;
  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Each bus state issues exactly one access; issued_q blocks a re-issue until ack.
  always_comb begin
    start     = 1'b0;
    is_read   = 1'b0;
    acc_addr  = A_CONTROL;
    acc_wdata = '0;
    case (state_q)
      ST_INIT:      begin acc_wdata = CONTROL_ENABLE; start = ~issued_q; end
`ifdef FRAME_FLIP_POLL_EN
      ST_POLL_RD:   begin acc_addr = A_SUBMIT; is_read = 1'b1; start = ~issued_q; end
`endif
      ST_WR_SRC:    begin acc_addr = A_SRC;    acc_wdata = addr_q;                      start = ~issued_q; end
      ST_WR_X:      begin acc_addr = A_XLEN;   acc_wdata = {8'h00, xlen_q - 24'd1};     start = ~issued_q; end
      ST_WR_Y:      begin acc_addr = A_YLEN;   acc_wdata = {16'h0000, ylen_q - 16'd1};  start = ~issued_q; end
      ST_WR_STRIDE: begin acc_addr = A_STRIDE; acc_wdata = {8'h00, stride_q};           start = ~issued_q; end
      ST_WR_SUB:    begin acc_addr = A_SUBMIT; acc_wdata = SUBMIT_GO;                   start = ~issued_q; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_INIT;
      issued_q  <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      vs_prev_q <= 1'b0;
      addr_q    <= '0;
      xlen_q    <= '0;
      ylen_q    <= '0;
      stride_q  <= '0;
`ifdef FRAME_FLIP_POLL_EN
      poll_cnt_q <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      vs_prev_q <= vsync;
      done_q    <= 1'b0;
`ifdef FRAME_FLIP_POLL_EN
      err_q     <= 1'b0;
`endif
      if (start) issued_q <= 1'b1;
      case (state_q)
        ST_INIT: begin
          busy_q <= 1'b1;
          if (ack) begin
            issued_q <= 1'b0;
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (req_valid && ready_q) begin
            addr_q   <= req_addr;
            xlen_q   <= req_xlen;
            ylen_q   <= req_ylen;
            stride_q <= req_stride;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= ST_WAIT_VS;
`ifdef FRAME_FLIP_POLL_EN
            poll_cnt_q <= '0;
`endif
          end
        end
        ST_WAIT_VS: begin
`ifdef FRAME_FLIP_POLL_EN
          if (vs_edge) state_q <= ST_POLL_RD;
`else
          if (vs_edge) state_q <= ST_WR_SRC;
`endif
        end
`ifdef FRAME_FLIP_POLL_EN
        ST_POLL_RD: begin
          if (ack) begin
            issued_q <= 1'b0;
            state_q  <= ST_POLL_WAIT;
          end
        end
        ST_POLL_WAIT: begin
          if (rd_valid) begin
            if (!rd_data[0]) begin
              state_q <= ST_WR_SRC;
            end else if (poll_cnt_q == POLL_LAST) begin
              err_q   <= 1'b1;
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              poll_cnt_q <= poll_cnt_q + 1'b1;
              state_q    <= ST_POLL_RD;
            end
          end
        end
`endif
        ST_WR_SRC:    if (ack) begin issued_q <= 1'b0; state_q <= ST_WR_X;      end
        ST_WR_X:      if (ack) begin issued_q <= 1'b0; state_q <= ST_WR_Y;      end
        ST_WR_Y:      if (ack) begin issued_q <= 1'b0; state_q <= ST_WR_STRIDE; end
        ST_WR_STRIDE: if (ack) begin issued_q <= 1'b0; state_q <= ST_WR_SUB;    end
        ST_WR_SUB: begin
          if (ack) begin
            issued_q <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  video_flip_avm_if #(.ADDR_W(ADDR_W)) u_avm (
    .clk               (clk),
    .resetn            (resetn),
    .start             (start),
    .is_read           (is_read),
    .addr              (acc_addr),
    .wdata             (acc_wdata),
    .ack               (ack),
    .rdata             (rd_data),
    .rvalid            (rd_valid),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid)
  );

endmodule
